// File: rtl/GamePkg.sv
// Shared game-wide types: tile encoding and the spawn/hold controller state enum.
package GamePkg;

  typedef enum logic [2:0] {
    BLANK  = 3'd0,
    TILE_I = 3'd1,
    TILE_O = 3'd2,
    TILE_T = 3'd3,
    TILE_S = 3'd4,
    TILE_Z = 3'd5,
    TILE_J = 3'd6,
    TILE_L = 3'd7
  } tile_type_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    OFFER     = 3'd2,
    ACTIVE    = 3'd3,
    GAME_OVER = 3'd4
  } spawn_state_t;

endpackage

// File: rtl/spawn_hold_ctrl_pkg.sv
// Local definitions for the spawn/hold controller.
package spawn_hold_ctrl_pkg;

  // Where the currently offered piece came from; only queue pieces dequeue.
  typedef enum logic {
    SRC_QUEUE = 1'b0,
    SRC_HOLD  = 1'b1
  } spawn_src_t;

endpackage

// File: rtl/spawn_hold_ctrl_if.sv
// Spawn offer handshake between the controller (master) and falling-piece logic (slave).
interface spawn_hold_ctrl_if;

  logic                spawn_valid;
  logic                spawn_ready;
  GamePkg::tile_type_t spawn_type;

  modport master (output spawn_valid, output spawn_type, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_type, output spawn_ready);

endinterface

// File: rtl/spawn_hold_ctrl.sv
// Sequences piece spawns from the next-pieces queue and the hold slot,
// offering each piece over a valid/ready handshake.
module spawn_hold_ctrl
  import GamePkg::*;
  import spawn_hold_ctrl_pkg::*;
#(
  parameter int FILL_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                game_start,
  input  logic                game_over,
  input  tile_type_t          queue_front,
  input  logic                spawn_req,
  input  logic                hold_req,
  output logic                pieces_remove,
  spawn_hold_ctrl_if.master   sp,
  output tile_type_t          hold_type,
  output logic                hold_used,
  output logic                fill_error,
  output logic [CNT_W-1:0]    pieces_spawned
);

  localparam int TO_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(FILL_TIMEOUT);

  spawn_state_t    state;
  spawn_src_t      src;
  tile_type_t      active_type;
  logic [TO_W-1:0] to_cnt;
  logic            handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A top-out in the same cycle abandons the offer, so no dequeue happens.
  assign handshake     = (state == OFFER) && sp.spawn_valid && sp.spawn_ready && !game_over;
  assign pieces_remove = handshake && (src == SRC_QUEUE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state          <= IDLE;
      src            <= SRC_QUEUE;
      sp.spawn_valid <= 1'b0;
      sp.spawn_type  <= BLANK;
      active_type    <= BLANK;
      hold_type      <= BLANK;
      hold_used      <= 1'b0;
      fill_error     <= 1'b0;
      pieces_spawned <= '0;
      to_cnt         <= '0;
    end else if (state == IDLE || state == GAME_OVER) begin
      if (game_start) begin
        state          <= FILL;
        hold_type      <= BLANK;
        hold_used      <= 1'b0;
        fill_error     <= 1'b0;
        pieces_spawned <= '0;
        to_cnt         <= '0;
      end
    end else if (game_over) begin
      state          <= GAME_OVER;
      sp.spawn_valid <= 1'b0;
      to_cnt         <= '0;
    end else begin
      case (state)
        FILL: begin
          if (queue_front != BLANK) begin
            src            <= SRC_QUEUE;
            sp.spawn_type  <= queue_front;
            sp.spawn_valid <= 1'b1;
            state          <= OFFER;
            to_cnt         <= '0;
          end else begin
            // Counter saturates; the error flag stays sticky while we keep waiting.
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (to_cnt >= TO_MAX - 1'b1) fill_error <= 1'b1;
          end
        end
        OFFER: begin
          if (sp.spawn_ready) begin
            state          <= ACTIVE;
            active_type    <= sp.spawn_type;
            sp.spawn_valid <= 1'b0;
            pieces_spawned <= sat_inc(pieces_spawned);
          end
        end
        ACTIVE: begin
          if (spawn_req) begin
            hold_used <= 1'b0;
            to_cnt    <= '0;
            state     <= FILL;
          end else if (hold_req && !hold_used) begin
            hold_used <= 1'b1;
            hold_type <= active_type;
            if (hold_type == BLANK) begin
              to_cnt <= '0;
              state  <= FILL;
            end else begin
              sp.spawn_type  <= hold_type;
              sp.spawn_valid <= 1'b1;
              src            <= SRC_HOLD;
              state          <= OFFER;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_hold_ctrl.sv
// Directed bench for spawn_hold_ctrl: offers are checked by a scoreboard monitor,
// state outputs by inline checks.
module tb_spawn_hold_ctrl;
  import GamePkg::*;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       game_start, game_over, spawn_req, hold_req;
  tile_type_t queue_front;
  logic       pieces_remove, hold_used, fill_error;
  tile_type_t hold_type;
  logic [15:0] pieces_spawned;

  spawn_hold_ctrl_if sp_if ();

  spawn_hold_ctrl #(.FILL_TIMEOUT(64), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .game_start     (game_start),
    .game_over      (game_over),
    .queue_front    (queue_front),
    .spawn_req      (spawn_req),
    .hold_req       (hold_req),
    .pieces_remove  (pieces_remove),
    .sp             (sp_if),
    .hold_type      (hold_type),
    .hold_used      (hold_used),
    .fill_error     (fill_error),
    .pieces_spawned (pieces_spawned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    tile_type_t t;
    logic       rm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_remove = 0;
  int   exp_remove = 0;
  logic remove_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input tile_type_t t, input logic rm);
    exp_t e;
    e.t = t;
    e.rm = rm;
    q.push_back(e);
    if (rm) exp_remove++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted offer is compared against the next scoreboard entry.
  always @(negedge clk) begin
    if (pieces_remove) n_remove++;
    if (remove_prev && pieces_remove) chk("remove_back_to_back", 1, 0);
    remove_prev <= pieces_remove;
    if (rst_l && sp_if.spawn_valid && sp_if.spawn_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_offer", int'(sp_if.spawn_type), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("offer_type", int'(sp_if.spawn_type), int'(e.t));
        chk("offer_remove", int'(pieces_remove), int'(e.rm));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic spawn_from_queue(input tile_type_t t);
    push(t, 1'b1);
    spawn_req = 1'b1;
    queue_front = t;
    tick();
    spawn_req = 1'b0;
    tick();
    tick();
    queue_front = BLANK;
  endtask

  initial begin
    rst_l = 1'b0;
    game_start = 1'b0;
    game_over = 1'b0;
    spawn_req = 1'b0;
    hold_req = 1'b0;
    queue_front = BLANK;
    sp_if.spawn_ready = 1'b1;
    tick();
    tick();
    chk("rst_spawn_valid", int'(sp_if.spawn_valid), 0);
    chk("rst_spawn_type", int'(sp_if.spawn_type), int'(BLANK));
    chk("rst_hold_type", int'(hold_type), int'(BLANK));
    chk("rst_hold_used", int'(hold_used), 0);
    chk("rst_fill_error", int'(fill_error), 0);
    chk("rst_pieces_spawned", int'(pieces_spawned), 0);
    chk("rst_remove", int'(pieces_remove), 0);
    rst_l = 1'b1;

    // First piece straight from the queue.
    push(TILE_T, 1'b1);
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    queue_front = TILE_T;
    tick();
    chk("first_offer_valid", int'(sp_if.spawn_valid), 1);
    tick();
    queue_front = BLANK;
    chk("first_valid_drops", int'(sp_if.spawn_valid), 0);
    chk("first_spawned", int'(pieces_spawned), 1);

    // Hold into an empty slot pulls the next queue piece.
    spawn_from_queue(TILE_I);
    chk("i_spawned", int'(pieces_spawned), 2);
    push(TILE_Z, 1'b1);
    hold_req = 1'b1;
    queue_front = TILE_Z;
    tick();
    hold_req = 1'b0;
    chk("hold_empty_type", int'(hold_type), int'(TILE_I));
    chk("hold_empty_used", int'(hold_used), 1);
    tick();
    tick();
    queue_front = BLANK;
    chk("hold_empty_spawned", int'(pieces_spawned), 3);
    hold_req = 1'b1;
    tick();
    hold_req = 1'b0;
    chk("hold_used_ignored_valid", int'(sp_if.spawn_valid), 0);
    chk("hold_used_ignored_type", int'(hold_type), int'(TILE_I));

    // Swap with a held piece: no dequeue, second hold ignored.
    spawn_from_queue(TILE_O);
    chk("o_hold_used_clear", int'(hold_used), 0);
    push(TILE_I, 1'b0);
    queue_front = TILE_J;
    hold_req = 1'b1;
    tick();
    hold_req = 1'b0;
    chk("swap_hold_type", int'(hold_type), int'(TILE_O));
    chk("swap_offer_type", int'(sp_if.spawn_type), int'(TILE_I));
    tick();
    chk("swap_spawned", int'(pieces_spawned), 5);
    hold_req = 1'b1;
    tick();
    hold_req = 1'b0;
    queue_front = BLANK;
    chk("swap_second_hold_type", int'(hold_type), int'(TILE_O));
    chk("swap_second_hold_valid", int'(sp_if.spawn_valid), 0);

    // Back-pressure: offer holds steady while ready is low.
    sp_if.spawn_ready = 1'b0;
    push(TILE_L, 1'b1);
    spawn_req = 1'b1;
    queue_front = TILE_L;
    tick();
    spawn_req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(sp_if.spawn_valid), 1);
      chk("stall_type", int'(sp_if.spawn_type), int'(TILE_L));
      chk("stall_remove", int'(pieces_remove), 0);
      tick();
    end
    sp_if.spawn_ready = 1'b1;
    tick();
    queue_front = BLANK;
    chk("stall_spawned", int'(pieces_spawned), 6);

    // spawn_req and hold_req together: spawn wins.
    push(TILE_J, 1'b1);
    spawn_req = 1'b1;
    hold_req = 1'b1;
    queue_front = TILE_J;
    tick();
    spawn_req = 1'b0;
    hold_req = 1'b0;
    chk("both_hold_type", int'(hold_type), int'(TILE_O));
    chk("both_hold_used", int'(hold_used), 0);
    tick();
    tick();
    queue_front = BLANK;
    chk("both_spawned", int'(pieces_spawned), 7);

    // Fill timeout after 64 blank cycles, then recovery.
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    repeat (63) tick();
    chk("fill_error_63", int'(fill_error), 0);
    tick();
    chk("fill_error_64", int'(fill_error), 1);
    push(TILE_S, 1'b1);
    queue_front = TILE_S;
    tick();
    tick();
    queue_front = BLANK;
    chk("after_timeout_spawned", int'(pieces_spawned), 8);
    chk("fill_error_sticky", int'(fill_error), 1);

    // Top-out mid-offer, then restart.
    sp_if.spawn_ready = 1'b0;
    spawn_req = 1'b1;
    queue_front = TILE_Z;
    tick();
    spawn_req = 1'b0;
    tick();
    chk("go_offer_valid", int'(sp_if.spawn_valid), 1);
    game_over = 1'b1;
    queue_front = BLANK;
    tick();
    game_over = 1'b0;
    chk("go_valid", int'(sp_if.spawn_valid), 0);
    chk("go_remove", int'(pieces_remove), 0);
    sp_if.spawn_ready = 1'b1;
    tick();
    chk("go_no_offer", int'(sp_if.spawn_valid), 0);
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    chk("restart_hold_type", int'(hold_type), int'(BLANK));
    chk("restart_spawned", int'(pieces_spawned), 0);
    chk("restart_fill_error", int'(fill_error), 0);
    push(TILE_Z, 1'b1);
    queue_front = TILE_Z;
    tick();
    tick();
    queue_front = BLANK;
    chk("restart_first_spawn", int'(pieces_spawned), 1);

    // Reset while an offer is pending.
    sp_if.spawn_ready = 1'b0;
    spawn_req = 1'b1;
    queue_front = TILE_L;
    tick();
    spawn_req = 1'b0;
    tick();
    rst_l = 1'b0;
    #1;
    chk("rst_offer_valid", int'(sp_if.spawn_valid), 0);
    chk("rst_offer_remove", int'(pieces_remove), 0);
    chk("rst_offer_spawned", int'(pieces_spawned), 0);
    tick();
    rst_l = 1'b1;
    queue_front = BLANK;
    sp_if.spawn_ready = 1'b1;
    tick();

    chk("scoreboard_drained", q.size(), 0);
    chk("remove_count", n_remove, exp_remove);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spawn_hold_ctrl.md
SPAWN_HOLD_CTRL -- requirements
Module: spawn_hold_ctrl

Interface
REQ-001 SHALL have parameter FILL_TIMEOUT, default 64: max cycles to wait for a non-BLANK queue front before flagging fill_error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the pieces_spawned counter.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst_l, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port game_start, input, 1: pulse; begins a game from IDLE or GAME_OVER.
REQ-006 SHALL have port game_over, input, 1: level; board reports top-out.
REQ-007 SHALL have port queue_front, input, tile_type_t: index 0 of the next-pieces queue.
REQ-008 SHALL have port spawn_req, input, 1: pulse; active piece locked, new piece needed.
REQ-009 SHALL have port hold_req, input, 1: pulse; player pressed hold.
REQ-010 SHALL have port spawn_ready, input, 1: falling-piece logic accepts spawn.
REQ-011 SHALL have port pieces_remove, output, 1: one-cycle pulse; dequeues queue front.
REQ-012 SHALL have port spawn_valid, output, 1: spawn_type is offered.
REQ-013 SHALL have port spawn_type, output, tile_type_t: piece to spawn.
REQ-014 SHALL have port hold_type, output, tile_type_t: held piece, BLANK if empty.
REQ-015 SHALL have port hold_used, output, 1: hold already used for the current piece.
REQ-016 SHALL have port fill_error, output, 1: sticky; FILL_TIMEOUT expired.
REQ-017 SHALL have port pieces_spawned, output, CNT_W: saturating count of completed spawns.

Function
REQ-018 SHALL implement states IDLE, FILL, OFFER, ACTIVE, GAME_OVER.
REQ-019 IDLE->FILL on game_start; hold_type:=BLANK, hold_used:=0, pieces_spawned:=0, fill_error:=0.
REQ-020 FILL: wait until queue_front != BLANK, then latch source=QUEUE, spawn_type:=queue_front, go to OFFER next cycle.
REQ-021 FILL: FILL_TIMEOUT consecutive cycles with BLANK front SHALL set fill_error; FSM keeps waiting.
REQ-022 OFFER: spawn_valid=1, spawn_type held stable until spawn_valid&&spawn_ready (handshake).
REQ-023 On handshake with source=QUEUE, pieces_remove SHALL pulse in that same cycle; never with source=HOLD.
REQ-024 On handshake: ->ACTIVE, active_type:=spawn_type, pieces_spawned+1 (saturate at all-ones), spawn_valid deasserts next cycle.
REQ-025 ACTIVE + spawn_req: hold_used:=0, ->FILL.
REQ-026 ACTIVE + hold_req, hold_used=0, hold_type=BLANK: hold_type:=active_type, hold_used:=1, ->FILL (queue source).
REQ-027 ACTIVE + hold_req, hold_used=0, hold_type!=BLANK: spawn_type:=hold_type, hold_type:=active_type, source=HOLD, hold_used:=1, ->OFFER.
REQ-028 hold_req with hold_used=1, or outside ACTIVE, SHALL be ignored.
REQ-029 spawn_req and hold_req in the same cycle: spawn_req wins, hold ignored.
REQ-030 spawn_req outside ACTIVE SHALL be ignored.
REQ-031 game_over=1 in any non-IDLE state: ->GAME_OVER next cycle, spawn_valid=0, no pieces_remove; an in-flight offer is abandoned.
REQ-032 GAME_OVER + game_start: ->FILL with REQ-019 clears applied; game_start outside IDLE/GAME_OVER ignored.
REQ-033 pieces_remove SHALL never assert in two consecutive cycles.

Reset
REQ-034 rst_l low: state=IDLE, spawn_valid=0, pieces_remove=0, spawn_type=BLANK, hold_type=BLANK, hold_used=0, fill_error=0, pieces_spawned=0, timeout counter=0.
REQ-035 Reset mid-offer SHALL drop the offer with no pieces_remove pulse.

Structure
REQ-036 tile_type_t and BLANK SHALL come from GamePkg; state enum spawn_state_t SHALL be added to GamePkg.
REQ-037 Timeout counter width SHALL be $clog2(FILL_TIMEOUT+1); no sub-modules except the shared register primitive.

Verification
REQ-038 Reset, game_start, queue_front=T from cycle 2, spawn_ready=1 -> spawn_valid on cycle 3 with T, pieces_remove one pulse, pieces_spawned=1.
REQ-039 ACTIVE with I, hold empty, hold_req -> hold_type=I, hold_used=1, next queue piece offered with pieces_remove.
REQ-040 ACTIVE with O, hold=I, hold_used=0, hold_req -> spawn_type=I, hold_type=O, no pieces_remove; second hold_req ignored.
REQ-041 spawn_ready=0 for 5 cycles in OFFER -> spawn_valid and spawn_type stable, no pieces_remove until ready.
REQ-042 queue_front=BLANK for 64 cycles in FILL -> fill_error=1 on cycle 64; S then arrives -> normal offer.
REQ-043 game_over during OFFER -> GAME_OVER, spawn_valid=0, no remove; game_start -> hold_type=BLANK, pieces_spawned=0.
